iobuf_sw_xcvr: RTL and testbench
================================

// Module: iobuf_sw_xcvr
// PURPOSE
// Core-side half-duplex controller for one bidirectional pad built from a tri-state IOBUF.
// Drives the pad's I (data) and T (tri-state, 1 = high-Z) inputs and consumes its O (pad readback).
// Serialises TX bytes onto the single wire and deserialises RX frames from it.
// Frame format: start bit 0, DATA_W bits LSB first, stop bit 1. The wire idles high via an external pull-up.
// PARAMETERS
// DATA_W    8   payload bits per frame (1..16)
// BIT_CYC   16  CLK cycles per bit (even, >=4)
// TURN_CYC  4   released-bus cycles after own stop bit before RX/TX re-arm (>=1)
// PORTS
// CLK       in   1       single clock, all flops rising-edge
// RST       in   1       asynchronous, active-high reset
// TX_DATA   in   DATA_W  byte to send; captured on accept
// TX_VALID  in   1       TX request
// TX_READY  out  1       high only in IDLE; accept = TX_VALID & TX_READY
// RX_DATA   out  DATA_W  last good received payload; holds until the next good frame
// RX_VALID  out  1       1-cycle pulse: good frame received
// RX_ERR    out  1       1-cycle pulse: stop bit sampled 0 (framing error)
// PAD_I     out  1       to IOBUF I
// PAD_T     out  1       to IOBUF T (1 = released / high-Z)
// PAD_O     in   1       from IOBUF O; asynchronous, passed through a 2-flop synchroniser
// BEHAVIOUR
// Reset (async assert, synchronous release): PAD_T=1, PAD_I=1, TX_READY=0, RX_VALID=0, RX_ERR=0, RX_DATA=0.
// Reset state is IDLE. Synchroniser flops and edge-history flop reset to 1.
// All outputs are registered. Bit counter runs 0..BIT_CYC-1. Bit index counter runs 0..DATA_W-1.
// States: IDLE, TX_START, TX_DATA, TX_STOP, TURN, RX_START, RX_DATA, RX_STOP.
// IDLE: PAD_T=1 and TX_READY=1. Falling edge on the synchronised line (prev=1, now=0) -> RX_START.
//   Otherwise, accept -> TX_START; TX_DATA is latched and TX_READY drops on the next cycle.
//   If a falling edge and TX_VALID occur in the same cycle, RX wins: no accept, and TX_READY goes 0.
// TX_START: PAD_T=0, PAD_I=0 for BIT_CYC cycles, starting the cycle after accept.
// TX_DATA: PAD_T=0, PAD_I=shift[0] for BIT_CYC cycles per bit, DATA_W bits.
// TX_STOP: PAD_T=0, PAD_I=1 for BIT_CYC cycles (actively drive high, then release).
//   Driven span is exactly (DATA_W+2)*BIT_CYC cycles.
// TURN: PAD_T=1, PAD_I=1 for TURN_CYC cycles. The synchroniser keeps running.
//   The edge-history flop is forced to 1 on exit, so the own-echo never triggers RX. Then -> IDLE.
// PAD_O is ignored for RX purposes in TX_* and TURN.
// RX_START: sample at count BIT_CYC/2-1 (mid-bit).
//   Sample 1 -> glitch: back to IDLE with no pulse.
//   Sample 0 -> RX_DATA state, counter restarted.
// RX_DATA: sample at every BIT_CYC-th cycle (mid-bit) and shift in LSB first; DATA_W samples.
// RX_STOP: sample at mid-bit, then go to IDLE on the next cycle.
//   Sample 1 -> RX_DATA<=shift and RX_VALID=1 for 1 cycle.
//   Sample 0 -> RX_ERR=1 for 1 cycle; RX_DATA is unchanged.
//   A line still low after an error does not re-trigger: a new RX needs a high then a falling edge.
// RX_VALID and RX_ERR are never high together. TX_READY=0 in every non-IDLE state.
// PAD_T is never 0 outside TX_*, including during and immediately after reset.
// Reset mid-frame: PAD_T=1 asynchronously, and the partial frame is discarded with no pulse.
// TESTING
// Reset: assert RST mid-TX_DATA -> PAD_T=1 the same cycle, TX_READY=0; after release -> IDLE, TX_READY=1 next cycle.
// TX 0xA5 (defaults): PAD_I at bit centres = 0,1,0,1,0,0,1,0,1,1.
//   PAD_T=0 for 160 cycles, then 1 for 4 cycles with TX_READY=0, then TX_READY=1.
// RX 0x3C at BIT_CYC=16 on PAD_O: RX_VALID pulses once ~ 8+9*16+2 sync cycles after the falling edge; RX_DATA=0x3C.
// Framing error: frame 0x81 with stop bit 0 -> RX_ERR one pulse, RX_VALID=0, RX_DATA keeps its previous value.
// Glitch: PAD_O low for 3 cycles -> return to IDLE, no RX_VALID/RX_ERR.
//   A good frame afterwards is received correctly.
// Collision: TX_VALID=1 and PAD_O falls in the same IDLE cycle -> RX proceeds and PAD_T stays 1.
//   TX is accepted in the first IDLE cycle after RX_STOP.

Source files
------------

// File: rtl/iobuf_sw_xcvr.sv
// Half-duplex single-wire transceiver driving one tri-state IOBUF pad.
// Serialises TX frames onto the wire and deserialises RX frames from it.
//
// Frame on the wire: start bit 0, DATA_W payload bits LSB first, stop bit 1.
// The wire idles high through an external pull-up.
//
// Ports:
//   CLK       single rising-edge clock
//   RST       asynchronous, active-high reset
//   TX_DATA   payload to send, captured on accept (TX_VALID & TX_READY)
//   TX_VALID  transmit request
//   TX_READY  high only while idle and able to accept
//   RX_DATA   last good received payload, held until the next good frame
//   RX_VALID  one-cycle pulse: good frame received
//   RX_ERR    one-cycle pulse: stop bit sampled low
//   PAD_I     to IOBUF I (data driven onto the pad)
//   PAD_T     to IOBUF T (1 = released / high-Z)
//   PAD_O     from IOBUF O, asynchronous pad readback
module iobuf_sw_xcvr #(
    parameter int DATA_W   = 8,
    parameter int BIT_CYC  = 16,
    parameter int TURN_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              RX_ERR,
    output logic              PAD_I,
    output logic              PAD_T,
    input  logic              PAD_O
);

    // One counter serves both bit timing and the turnaround gap.
    localparam int CNT_MAX = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_TURN,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    logic sync1_q, sync2_q;
    logic prev_q, prev_d;

    logic              pad_t_q, pad_t_d;
    logic              pad_i_q, pad_i_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic line;
    logic fall;
    logic bit_end;
    logic half_bit;
    logic rx_good;
    logic rx_bad;

    assign line     = sync2_q;
    assign fall     = prev_q & ~line;
    assign bit_end  = (cnt_q == BIT_LAST);
    assign half_bit = (cnt_q == HALF_LAST);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            pad_t_q    <= 1'b1;
            pad_i_q    <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            sync1_q    <= PAD_O;
            sync2_q    <= sync1_q;
            prev_q     <= prev_d;
            pad_t_q    <= pad_t_d;
            pad_i_q    <= pad_i_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        prev_d  = line;
        rx_good = 1'b0;
        rx_bad  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // A falling edge beats a simultaneous TX request.
                if (fall) begin
                    state_d = S_RX_START;
                end else if (TX_VALID && tx_ready_q) begin
                    state_d = S_TX_START;
                    shift_d = TX_DATA;
                end
            end

            S_TX_START: begin
                if (bit_end) begin
                    state_d = S_TX_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            S_TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_TX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_TX_STOP: begin
                if (bit_end) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                end
            end

            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    // Our own echo must never look like an incoming start bit.
                    prev_d  = 1'b1;
                end
            end

            S_RX_START: begin
                if (half_bit) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // Line back high at mid-bit means the edge was a glitch.
                    state_d = line ? S_IDLE : S_RX_DATA;
                end
            end

            S_RX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    shift_d[DATA_W-1] = line;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_RX_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rx_good = line;
                    rx_bad  = ~line;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the state being entered so that
    // the pad follows the state on the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pad_t_d    = 1'b1;
        pad_i_d    = 1'b1;
        tx_ready_d = (state_d == S_IDLE);
        rx_valid_d = rx_good;
        rx_err_d   = rx_bad;
        rx_data_d  = rx_good ? shift_q : rx_data_q;

        case (state_d)
            S_TX_START: begin
                pad_t_d = 1'b0;
                pad_i_d = 1'b0;
            end
            S_TX_DATA: begin
                pad_t_d = 1'b0;
                pad_i_d = shift_d[0];
            end
            S_TX_STOP: begin
                pad_t_d = 1'b0;
                pad_i_d = 1'b1;
            end
            default: begin
                pad_t_d = 1'b1;
                pad_i_d = 1'b1;
            end
        endcase
    end

    assign PAD_T    = pad_t_q;
    assign PAD_I    = pad_i_q;
    assign TX_READY = tx_ready_q;
    assign RX_VALID = rx_valid_q;
    assign RX_ERR   = rx_err_q;
    assign RX_DATA  = rx_data_q;

endmodule

// File: tb/tb_iobuf_sw_xcvr.sv
// Self-checking bench for iobuf_sw_xcvr (default parameters).
// Wire model: PAD_O follows the DUT when it drives, else the external line.
module tb_iobuf_sw_xcvr;

    localparam int BIT_CYC = 16;
    localparam int NBITS   = 10;
    localparam int DRIVE   = NBITS * BIT_CYC;
    localparam int TURN    = 4;
    // External line change in cycle D -> 2 sync cycles, 1 detect cycle,
    // half a bit to the start centre, then 9 full bits to the stop centre.
    localparam int RX_LAT  = 3 + BIT_CYC / 2 + 9 * BIT_CYC;

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       pad_i;
    logic       pad_t;
    logic       pad_o;
    logic       ext = 1'b1;

    int         cyc = 0;
    int         nvec = 0;
    int         nfail = 0;
    int         tx_acc = -100000;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_last = 8'h00;
    ev_t        ev_q[$];
    bit         line_q[$];

    assign pad_o = pad_t ? ext : pad_i;

    iobuf_sw_xcvr dut (
        .CLK      (clk),
        .RST      (rst),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_ERR   (rx_err),
        .PAD_I    (pad_i),
        .PAD_T    (pad_t),
        .PAD_O    (pad_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External line driver: one queued bit per cycle, idle high.
    initial forever begin
        @(posedge clk);
        #1;
        if (line_q.size() != 0) ext = line_q.pop_front();
        else ext = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit stop);
        bit b;
        for (int j = 0; j < NBITS; j++) begin
            if (j == 0) b = 1'b0;
            else if (j == NBITS - 1) b = stop;
            else b = d[j-1];
            repeat (BIT_CYC) line_q.push_back(b);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tx_byte  = d;
        tx_acc   = cyc + 1;
        wait_neg(tx_acc);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Model compare, every cycle.
    always @(negedge clk) begin
        int         k;
        bit         ev_v;
        bit         ev_e;
        logic [9:0] frame;
        if (rst) begin
            rx_last = 8'h00;
            chk("rst_pad_t", 32'(pad_t), 1);
            chk("rst_pad_i", 32'(pad_i), 1);
            chk("rst_tx_ready", 32'(tx_ready), 0);
            chk("rst_rx_valid", 32'(rx_valid), 0);
            chk("rst_rx_err", 32'(rx_err), 0);
            chk("rst_rx_data", 32'(rx_data), 0);
        end else begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            while (ev_q.size() != 0 && ev_q[0].cyc < cyc) ev_q.delete(0);
            if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
                ev_v = ev_q[0].good;
                ev_e = !ev_q[0].good;
                if (ev_q[0].good) rx_last = ev_q[0].data;
                ev_q.delete(0);
            end
            chk("rx_valid", 32'(rx_valid), 32'(ev_v));
            chk("rx_err", 32'(rx_err), 32'(ev_e));
            chk("rx_data", 32'(rx_data), 32'(rx_last));
            chk("pulse_excl", 32'(rx_valid & rx_err), 0);
            frame = {1'b1, tx_byte, 1'b0};
            k = cyc - tx_acc;
            if (k >= 0 && k < DRIVE) begin
                chk("tx_pad_t", 32'(pad_t), 0);
                chk("tx_pad_i", 32'(pad_i), 32'(frame[k / BIT_CYC]));
                chk("tx_ready_busy", 32'(tx_ready), 0);
            end else if (k >= DRIVE && k < DRIVE + TURN) begin
                chk("turn_pad_t", 32'(pad_t), 1);
                chk("turn_pad_i", 32'(pad_i), 1);
                chk("turn_ready", 32'(tx_ready), 0);
            end else begin
                chk("idle_pad_t", 32'(pad_t), 1);
                if (k == DRIVE + TURN) chk("tx_ready_back", 32'(tx_ready), 1);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d expected finish earlier", cyc);
        $fatal(1);
    end

    initial begin
        int         d;
        int         r;
        logic [9:0] a5_lit;
        a5_lit = 10'b1101001010;

        // Reset release
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        r = cyc;
        wait_neg(r + 1);
        chk("rel_ready", 32'(tx_ready), 1);

        // TX 0xA5 with hand-computed bit centres
        wait_neg(cyc + 2);
        start_tx(8'hA5);
        for (int b = 0; b < NBITS; b++) begin
            wait_neg(tx_acc + BIT_CYC / 2 + BIT_CYC * b);
            chk("a5_centre", 32'(pad_i), 32'(a5_lit[b]));
        end
        wait_neg(tx_acc + DRIVE - 1);
        chk("a5_last_drv", 32'(pad_t), 0);
        wait_neg(tx_acc + DRIVE + TURN - 1);
        chk("a5_turn_ready", 32'(tx_ready), 0);
        wait_neg(tx_acc + DRIVE + TURN);
        chk("a5_ready", 32'(tx_ready), 1);
        wait_neg(cyc + 10);

        // RX 0x3C
        d = cyc + 1;
        push_frame(8'h3C, 1'b1);
        ev_q.push_back('{d + RX_LAT, 1'b1, 8'h3C});
        wait_neg(d + RX_LAT - 1);
        chk("rx3c_early", 32'(rx_valid), 0);
        wait_neg(d + RX_LAT);
        chk("rx3c_valid", 32'(rx_valid), 1);
        chk("rx3c_data", 32'(rx_data), 32'h3C);
        wait_neg(d + RX_LAT + 1);
        chk("rx3c_pulse", 32'(rx_valid), 0);
        wait_neg(d + DRIVE + 10);

        // Framing error, line held low afterwards
        d = cyc + 1;
        push_frame(8'h81, 1'b0);
        repeat (20) line_q.push_back(1'b0);
        ev_q.push_back('{d + RX_LAT, 1'b0, 8'h00});
        wait_neg(d + RX_LAT);
        chk("ferr_err", 32'(rx_err), 1);
        chk("ferr_valid", 32'(rx_valid), 0);
        chk("ferr_data", 32'(rx_data), 32'h3C);
        wait_neg(d + DRIVE + 20 + 30);

        // Glitch then a good frame
        d = cyc + 1;
        repeat (3) line_q.push_back(1'b0);
        wait_neg(d + 3);
        chk("glitch_busy", 32'(tx_ready), 0);
        wait_neg(d + 40);
        chk("glitch_ready", 32'(tx_ready), 1);
        d = cyc + 1;
        push_frame(8'h96, 1'b1);
        ev_q.push_back('{d + RX_LAT, 1'b1, 8'h96});
        wait_neg(d + DRIVE + 10);
        chk("rx96_data", 32'(rx_data), 32'h96);

        // Collision: TX request on the same cycle the synced line falls
        d = cyc + 1;
        push_frame(8'h55, 1'b1);
        ev_q.push_back('{d + RX_LAT, 1'b1, 8'h55});
        tx_byte = 8'hC3;
        tx_acc  = d + RX_LAT + 1;
        wait_neg(d + 2);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        wait_neg(d + 3);
        chk("coll_ready", 32'(tx_ready), 0);
        chk("coll_pad_t", 32'(pad_t), 1);
        wait_neg(tx_acc);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("coll_tx_go", 32'(pad_t), 0);
        wait_neg(tx_acc + DRIVE + TURN + 10);
        chk("rx55_data", 32'(rx_data), 32'h55);

        // All-zero payload
        d = cyc + 1;
        push_frame(8'h00, 1'b1);
        ev_q.push_back('{d + RX_LAT, 1'b1, 8'h00});
        wait_neg(d + DRIVE + 10);
        chk("rx00_data", 32'(rx_data), 32'h00);

        // Reset in the middle of TX_DATA
        start_tx(8'h5A);
        wait_neg(tx_acc + 50);
        #2 rst = 1'b1;
        tx_acc = -100000;
        #1;
        chk("mid_rst_pad_t", 32'(pad_t), 1);
        chk("mid_rst_ready", 32'(tx_ready), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        r = cyc;
        wait_neg(r + 1);
        chk("mid_rel_ready", 32'(tx_ready), 1);
        chk("mid_rel_pad_t", 32'(pad_t), 1);

        // All-ones TX after recovery
        wait_neg(cyc + 3);
        start_tx(8'hFF);
        wait_neg(tx_acc + DRIVE + TURN + 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
